// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requestor and backing-memory bundle for mem_port_arbiter; slave modport = arbiter side, master modport = requestors plus memory.
interface mem_port_arbiter_if #(
  parameter int NUM_PORTS = 5,
  parameter int ADDR_W    = 23,
  parameter int DATA_W    = 16
);
  logic [NUM_PORTS-1:0]        req;
  logic [NUM_PORTS-1:0]        we;
  logic [NUM_PORTS*ADDR_W-1:0] addr;
  logic [NUM_PORTS*DATA_W-1:0] wdata;
  logic [NUM_PORTS-1:0]        gnt;
  logic [NUM_PORTS-1:0]        done;
  logic [NUM_PORTS-1:0]        err;
  logic [DATA_W-1:0]           rdata;
  logic                        mem_as;
  logic                        mem_rw;
  logic [ADDR_W-1:0]           mem_addr;
  logic [DATA_W-1:0]           mem_wdata;
  logic [DATA_W-1:0]           mem_rdata;
  logic                        mem_done;
  modport slave (
    input  req, we, addr, wdata, mem_rdata, mem_done,
    output gnt, done, err, rdata, mem_as, mem_rw, mem_addr, mem_wdata
  );
  modport master (
    output req, we, addr, wdata, mem_rdata, mem_done,
    input  gnt, done, err, rdata, mem_as, mem_rw, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: N-port round-robin arbiter onto one single-outstanding memory with done/err pulses and watchdog; ports clk, rst (async high), bus (slave); MEM_ARB_PRIO0_EN gives port 0 fixed priority.
module mem_port_arbiter #(
  parameter int NUM_PORTS = 5,
  parameter int ADDR_W    = 23,
  parameter int DATA_W    = 16,
  parameter int TIMEOUT   = 255
) (
  input logic clk,
  input logic rst,
  mem_port_arbiter_if.slave bus
);
  localparam int PW = $clog2(NUM_PORTS);
  localparam int CW = $clog2(TIMEOUT + 2);
  localparam logic [CW-1:0] TLAST = CW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t              state_q, state_d;
  logic [PW-1:0]       ptr_q, ptr_d, port_q, port_d, sel;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                mem_as_q, mem_as_d, mem_rw_q, mem_rw_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d, rdata_q, rdata_d;
  logic [NUM_PORTS-1:0] done_q, done_d, err_q, err_d;
  logic                found, keep_ptr;
  logic [ADDR_W-1:0]   addr_a [NUM_PORTS];
  logic [DATA_W-1:0]   wdata_a [NUM_PORTS];
  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_unpack
    assign addr_a[i]  = bus.addr[i*ADDR_W +: ADDR_W];
    assign wdata_a[i] = bus.wdata[i*DATA_W +: DATA_W];
  end
`ifdef MEM_ARB_PRIO0_EN
  assign keep_ptr = bus.req[0];
`else
  assign keep_ptr = 1'b0;
`endif
  assign found = |bus.req;
  always_comb begin
    sel = '0;
    for (int j = NUM_PORTS; j >= 1; j--)
      if (bus.req[PW'((int'(ptr_q) + j) % NUM_PORTS)]) sel = PW'((int'(ptr_q) + j) % NUM_PORTS);
    sel = keep_ptr ? '0 : sel;
  end
  assign bus.gnt = (state_q == IDLE && !rst && found) ? (NUM_PORTS'(1) << sel) : '0;
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    port_d      = port_q;
    cnt_d       = cnt_q;
    mem_as_d    = mem_as_q;
    mem_rw_d    = mem_rw_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    done_d      = '0;
    err_d       = '0;
    rdata_d     = '0;
    if (state_q == IDLE) begin
      if (found) begin
        state_d     = BUSY;
        port_d      = sel;
        ptr_d       = keep_ptr ? ptr_q : sel;
        cnt_d       = '0;
        mem_as_d    = 1'b1;
        mem_rw_d    = bus.we[sel];
        mem_addr_d  = addr_a[sel];
        mem_wdata_d = wdata_a[sel];
      end
    end else if (bus.mem_done) begin
      state_d  = IDLE;
      mem_as_d = 1'b0;
      done_d   = NUM_PORTS'(1) << port_q;
      rdata_d  = mem_rw_q ? '0 : bus.mem_rdata;
    end else if (TIMEOUT != 0 && cnt_q == TLAST) begin
      state_d  = IDLE;
      mem_as_d = 1'b0;
      done_d   = NUM_PORTS'(1) << port_q;
      err_d    = NUM_PORTS'(1) << port_q;
    end else begin
      cnt_d = &cnt_q ? cnt_q : cnt_q + 1'b1;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= PW'(NUM_PORTS - 1);
      port_q      <= '0;
      cnt_q       <= '0;
      mem_as_q    <= 1'b0;
      mem_rw_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      done_q      <= '0;
      err_q       <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      port_q      <= port_d;
      cnt_q       <= cnt_d;
      mem_as_q    <= mem_as_d;
      mem_rw_q    <= mem_rw_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      done_q      <= done_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
    end
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.rdata     = rdata_q;
  assign bus.mem_as    = mem_as_q;
  assign bus.mem_rw    = mem_rw_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Parametrised N-port round-robin arbiter that multiplexes compute-side memory requestors onto one single-outstanding backing memory interface (SDRAM model or controller).
- Replaces the fixed five-port rotating-counter mux with:
  - a request/grant handshake;
  - latched transactions;
  - per-port completion and error reporting;
  - a watchdog timeout.
- Sits between the per-port memory handles and the backing memory.

Parameters:
NUM_PORTS, 5, number of requestor ports (2..16)
ADDR_W, 23, address width
DATA_W, 16, data width
TIMEOUT, 255, max BUSY cycles before abort; 0 disables watchdog

Ports:
- Clocking and reset (already decided): one clock; reset is asynchronous and active-high.
clk  in  1  clock
rst  in  1  asynchronous active-high reset
req  in  NUM_PORTS  per-port request, held until granted
we  in  NUM_PORTS  per-port write enable (1=write, 0=read)
addr  in  NUM_PORTS*ADDR_W  per-port address, port i at [i*ADDR_W +: ADDR_W]
wdata  in  NUM_PORTS*DATA_W  per-port write data, same packing
gnt  out  NUM_PORTS  one-hot acceptance, combinational
done  out  NUM_PORTS  one-cycle completion pulse
err  out  NUM_PORTS  one-cycle timeout pulse, coincident with done
rdata  out  DATA_W  read data, valid only while any done bit is high
mem_as  out  1  backing memory access strobe
mem_rw  out  1  1=write
mem_addr  out  ADDR_W  latched address
mem_wdata  out  DATA_W  latched write data
mem_rdata  in  DATA_W  backing read data
mem_done  in  1  backing completion, sampled only in BUSY

Behaviour:
- Reset values: all registered outputs 0; FSM = IDLE; rr pointer = NUM_PORTS-1, so port 0 is searched first; watchdog counter 0.
- Reset mid-transaction aborts it: no done or err is issued for the aborted transaction.
- FSM states: IDLE, BUSY.

IDLE:
- If any req bit is set, pick the first requesting port scanning from (ptr+1) mod NUM_PORTS upward with wrap-around.
- Drive gnt[k]=1 combinationally in that cycle. gnt is 0 in BUSY.
- At the clock edge:
  - latch k, we[k], addr[k], wdata[k];
  - ptr <= k;
  - mem_as <= 1, mem_rw <= we[k], mem_addr / mem_wdata <= latched values;
  - counter <= 0;
  - state <= BUSY.
- Requestor deasserts or changes req after the edge where gnt was seen. A still-high req is treated as a new request.
- No req: stay in IDLE, gnt = 0.

BUSY:
- mem_as, mem_rw, mem_addr and mem_wdata are held stable.
- mem_done sampled high:
  - next cycle: done[k]=1; rdata = mem_rdata captured on that edge (0 for writes); mem_as=0; state=IDLE.
  - A new grant may occur in that same IDLE cycle, so back-to-back transactions cost one cycle with mem_as low.
- TIMEOUT != 0 and counter reaches TIMEOUT-1 without mem_done:
  - next cycle: done[k]=1, err[k]=1, rdata=0, mem_as=0, state=IDLE.
- mem_done and timeout in the same cycle: mem_done wins, err=0.
- Otherwise the counter increments, saturating.

Other rules:
- mem_done in IDLE is ignored.
- done, err and gnt are each at most one-hot.
- rdata holds 0 whenever no done bit is high.
- Single outstanding transaction: a port granted while its earlier done is not yet seen is impossible by construction.
- Fairness: with all ports requesting continuously, grants rotate 0,1,...,NUM_PORTS-1,0.

Optional Feature:
- Macro: MEM_ARB_PRIO0_EN.
- Defined:
  - port 0 wins whenever req[0] is high in IDLE, regardless of ptr;
  - a port-0 grant does not update ptr;
  - other ports stay round-robin among themselves.
- Undefined: pure round-robin as above.

Test Plan:
- Reset, then one read: req[2]=1, we=0, addr=0x10; backing done after 4 BUSY cycles with mem_rdata=0x00AB -> gnt[2] in cycle 0; mem_as high cycles 1-4; done[2]=1 with rdata=0x00AB in cycle 5; err=0.
- All 5 ports requesting continuously, 3-cycle backing latency -> grant order 0,1,2,3,4,0; mem_as low exactly one cycle between transactions.
- Write req[1] with addr=0x7FFFFF, wdata=0xBEEF -> mem_rw=1, mem_addr=0x7FFFFF, mem_wdata=0xBEEF, all stable until mem_done; done[1] pulse with rdata=0.
- TIMEOUT=8, backing never asserts mem_done -> done[3] and err[3] pulse 8 cycles after mem_as rises; mem_as falls; next request is granted normally.
- Assert rst for one cycle mid-BUSY -> all outputs 0 immediately; no done/err for the aborted port; the next grant goes to the lowest requesting port.
- With MEM_ARB_PRIO0_EN: ports 0 and 3 requesting continuously -> port 0 granted every transaction; ptr unchanged; without the macro -> alternates 0,3,0,3.
